// File: rtl/arith_pkg.sv
// Shared definitions for the accumulator sequencer: widths, ALU select codes,
// FSM state encoding and the command payload.
package arith_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SEL_W = 3;

  localparam logic [SEL_W-1:0] SEL_ONE  = 3'd0;
  localparam logic [SEL_W-1:0] SEL_DEC  = 3'd1;
  localparam logic [SEL_W-1:0] SEL_ADD  = 3'd2;
  localparam logic [SEL_W-1:0] SEL_SUB  = 3'd3;
  localparam logic [SEL_W-1:0] SEL_MUL  = 3'd4;
  localparam logic [SEL_W-1:0] SEL_MULN = 3'd5;
  localparam logic [SEL_W-1:0] SEL_DBL  = 3'd6;
  localparam logic [SEL_W-1:0] SEL_INC  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [SEL_W-1:0] select;
    logic [WIDTH-1:0] data;
    logic             load;
    logic             chain;
  } cmd_t;

endpackage

// File: rtl/arith_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; DEPTH must be a power of 2.
// A push while full is accepted only when a pop happens in the same cycle.
module arith_cmd_fifo
  import arith_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  cmd_t din,
  input  logic pop,
  output cmd_t dout,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of 2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/arith_acc_sequencer.sv
// Issue stage for the combinational arithmetic unit: accumulator, stored carry,
// one command in flight. Define ARITH_CMD_FIFO_EN to add a command FIFO in front.
module arith_acc_sequencer #(
  parameter int unsigned WIDTH      = arith_pkg::WIDTH,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_select,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_load,
  input  logic             cmd_chain,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_cmp,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             res_cmp
);
  import arith_pkg::*;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [WIDTH-1:0] op_data;
  logic             op_load;
  logic             take;
  cmd_t             cmd_pkt;
  cmd_t             cmd_in;
  logic [WIDTH-1:0] next_acc;
  logic             next_carry;
  logic             next_cmp;

  assign cmd_pkt = '{select: cmd_select, data: cmd_data, load: cmd_load, chain: cmd_chain};

`ifdef ARITH_CMD_FIFO_EN
  logic fifo_full;
  logic fifo_empty;
  cmd_t fifo_dout;

  // Acceptance depends only on FIFO occupancy, never on the FSM
  assign cmd_ready = ~fifo_full & ~rst;
  assign take      = (state == IDLE) & ~fifo_empty;
  assign cmd_in    = fifo_dout;

  arith_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (cmd_valid & cmd_ready),
    .din  (cmd_pkt),
    .pop  (take),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );
`else
  assign take   = cmd_valid & cmd_ready;
  assign cmd_in = cmd_pkt;
`endif

  // Writeback selection: loads bypass the ALU and keep the stored carry
  always_comb begin
    next_acc   = alu_result;
    next_carry = alu_cout;
    next_cmp   = alu_cmp;
    if (op_load) begin
      next_acc   = op_data;
      next_carry = carry;
      next_cmp   = (acc == op_data);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      carry     <= 1'b0;
      op_data   <= '0;
      op_load   <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      alu_cin   <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_cmp   <= 1'b0;
`ifndef ARITH_CMD_FIFO_EN
      cmd_ready <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifndef ARITH_CMD_FIFO_EN
          cmd_ready <= 1'b1;
`endif
          // ALU operands are launched here so they are stable for all of EXEC
          if (take) begin
            op_data <= cmd_in.data;
            op_load <= cmd_in.load;
            alu_a   <= acc;
            alu_b   <= cmd_in.data;
            alu_sel <= cmd_in.select;
            alu_cin <= cmd_in.chain & carry;
            state   <= EXEC;
`ifndef ARITH_CMD_FIFO_EN
            cmd_ready <= 1'b0;
`endif
          end
        end
        EXEC: begin
          acc       <= next_acc;
          carry     <= next_carry;
          res_data  <= next_acc;
          res_carry <= next_carry;
          res_cmp   <= next_cmp;
          res_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
`ifndef ARITH_CMD_FIFO_EN
            cmd_ready <= 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arith_acc_sequencer.sv
// Directed bench for arith_acc_sequencer with a behavioural arithmetic unit.
module tb_arith_acc_sequencer;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_select = 3'd0;
  logic [W-1:0] cmd_data = '0;
  logic         cmd_load = 1'b0;
  logic         cmd_chain = 1'b0;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_sel;
  logic         alu_cin;
  logic [W-1:0] alu_result;
  logic         alu_cout;
  logic         alu_cmp;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_data;
  logic         res_carry;
  logic         res_cmp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arith_acc_sequencer #(.WIDTH(W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_select(cmd_select),
    .cmd_data(cmd_data), .cmd_load(cmd_load), .cmd_chain(cmd_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_cmp(alu_cmp),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .res_cmp(res_cmp)
  );

  // Behavioural arithmetic unit
  logic [W:0]     tmp;
  logic [2*W-1:0] prod;
  always_comb begin
    tmp  = '0;
    prod = alu_a * alu_b;
    case (alu_sel)
      3'd0: tmp = {1'b0, 16'h0001};
      3'd1: tmp = {1'b0, alu_a} - 17'd1;
      3'd2: tmp = {1'b0, alu_a} + {1'b0, alu_b} + 17'(alu_cin);
      3'd3: tmp = {1'b0, alu_a} - {1'b0, alu_b} - 17'(alu_cin);
      3'd4: tmp = {|prod[2*W-1:W], prod[W-1:0]};
      3'd5: tmp = {1'b0, W'(-prod[W-1:0])};
      3'd6: tmp = {1'b0, alu_a} + {1'b0, alu_a};
      default: tmp = {1'b0, alu_a} + 17'd1;
    endcase
    alu_result = tmp[W-1:0];
    alu_cout   = tmp[W];
    alu_cmp    = (alu_a == alu_b);
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Waits for cmd_ready, then completes one handshake; returns #1 after that edge
  task automatic send(input logic [2:0] sel, input logic [W-1:0] data,
                      input logic load, input logic chain);
    int n = 0;
    @(negedge clk);
    cmd_select = sel; cmd_data = data; cmd_load = load; cmd_chain = chain;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL send_timeout: cmd_ready=%0b required 1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic recv(output logic [W-1:0] d, output logic c, output logic m);
    int n = 0;
    res_ready = 1'b1;
    while (!res_valid && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!res_valid) begin
      errors++;
      $display("FAIL recv_timeout: res_valid=%0b required 1", res_valid);
    end
    d = res_data; c = res_carry; m = res_cmp;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %0b want 0", cmd_ready); end
    checks++;
    if ({res_valid, res_data, res_carry, res_cmp} !== '0) begin
      errors++; $display("FAIL reset_res: got v=%0b d=%h c=%0b m=%0b want all 0", res_valid, res_data, res_carry, res_cmp);
    end
    checks++;
    if ({alu_a, alu_b, alu_sel, alu_cin} !== '0) begin
      errors++; $display("FAIL reset_alu: got a=%h b=%h s=%0d ci=%0b want all 0", alu_a, alu_b, alu_sel, alu_cin);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_one_latency;
    logic [W-1:0] d; logic c, m;
    send(3'd0, 16'h1234, 1'b1, 1'b0);
    recv(d, c, m);
    checks++;
    if (d !== 16'h1234 || c !== 1'b0) begin errors++; $display("FAIL load_1234: got d=%h c=%0b want 1234 0", d, c); end
    send(3'd0, 16'h1234, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL latency_early: res_valid=%0b want 0", res_valid); end
    checks++;
    if (alu_a !== 16'h1234 || alu_b !== 16'h1234 || alu_sel !== 3'd0 || alu_cin !== 1'b0) begin
      errors++; $display("FAIL exec_operands: a=%h b=%h s=%0d ci=%0b want 1234 1234 0 0", alu_a, alu_b, alu_sel, alu_cin);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 16'h0001 || res_carry !== 1'b0 || res_cmp !== 1'b1) begin
      errors++; $display("FAIL one_result: v=%0b d=%h c=%0b m=%0b want 1 0001 0 1", res_valid, res_data, res_carry, res_cmp);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== 16'h0001 || res_cmp !== 1'b1
`ifndef ARITH_CMD_FIFO_EN
          || cmd_ready !== 1'b0
`endif
         ) begin
        errors++; $display("FAIL stall_hold%0d: v=%0b d=%h m=%0b rdy=%0b want 1 0001 1 0", i, res_valid, res_data, res_cmp, cmd_ready);
      end
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release: v=%0b rdy=%0b want 0 1", res_valid, cmd_ready);
    end
  endtask

  task automatic test_rst_mid;
    logic [W-1:0] d; logic c, m;
    send(3'd0, 16'h00AA, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if (res_valid !== 1'b0 || alu_a !== 16'h0000 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid: v=%0b a=%h rdy=%0b want 0 0000 0", res_valid, alu_a, cmd_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    send(3'd7, 16'h0000, 1'b0, 1'b0);
    recv(d, c, m);
    checks++;
    if (d !== 16'h0001 || c !== 1'b0) begin errors++; $display("FAIL inc_after_rst: got d=%h c=%0b want 0001 0", d, c); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] d; logic c, m;
    int hs = 0, rs = 0, n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    cmd_select = 3'd7; cmd_data = '0; cmd_load = 1'b0; cmd_chain = 1'b0;
    cmd_valid = 1'b1; res_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (cmd_ready) hs++;
      if (res_valid) rs++;
      @(negedge clk);
    end
    cmd_valid = 1'b0; res_ready = 1'b0;
    checks++;
    if (hs != 3 || rs != 3) begin errors++; $display("FAIL b2b_rate: hs=%0d res=%0d want 3 3", hs, rs); end
    send(3'd7, 16'h0000, 1'b0, 1'b0);
    recv(d, c, m);
    checks++;
    if (d !== 16'h0005) begin errors++; $display("FAIL b2b_acc: got %h want 0005", d); end
  endtask

  task automatic test_chain;
    logic [W-1:0] d; logic c, m;
    send(3'd0, 16'hFFFF, 1'b1, 1'b0);
    recv(d, c, m);
    checks++;
    if (d !== 16'hFFFF || c !== 1'b0 || m !== 1'b0) begin errors++; $display("FAIL load_ffff: got d=%h c=%0b m=%0b want ffff 0 0", d, c, m); end
    send(3'd2, 16'h0001, 1'b0, 1'b0);
    recv(d, c, m);
    checks++;
    if (d !== 16'h0000 || c !== 1'b1) begin errors++; $display("FAIL add_wrap: got d=%h c=%0b want 0000 1", d, c); end
    send(3'd2, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (alu_cin !== 1'b1 || alu_a !== 16'h0000) begin errors++; $display("FAIL chain_cin: ci=%0b a=%h want 1 0000", alu_cin, alu_a); end
    recv(d, c, m);
    checks++;
    if (d !== 16'h0001 || c !== 1'b0) begin errors++; $display("FAIL chain_add: got d=%h c=%0b want 0001 0", d, c); end
  endtask

  task automatic test_dbl_load_carry;
    logic [W-1:0] d; logic c, m;
    send(3'd0, 16'h8001, 1'b1, 1'b0);
    recv(d, c, m);
    send(3'd6, 16'h0000, 1'b0, 1'b0);
    recv(d, c, m);
    checks++;
    if (d !== 16'h0002 || c !== 1'b1) begin errors++; $display("FAIL dbl: got d=%h c=%0b want 0002 1", d, c); end
    send(3'd0, 16'h0005, 1'b1, 1'b0);
    recv(d, c, m);
    checks++;
    if (d !== 16'h0005 || c !== 1'b1 || m !== 1'b0) begin errors++; $display("FAIL load_keeps_carry: got d=%h c=%0b m=%0b want 0005 1 0", d, c, m); end
    send(3'd3, 16'h0003, 1'b0, 1'b0);
    recv(d, c, m);
    checks++;
    if (d !== 16'h0002) begin errors++; $display("FAIL sub: got %h want 0002", d); end
  endtask

`ifdef ARITH_CMD_FIFO_EN
  task automatic test_fifo;
    logic [W-1:0] d; logic c, m;
    logic [2:0]   sels [5] = '{3'd0, 3'd7, 3'd7, 3'd0, 3'd7};
    logic [W-1:0] vals [5] = '{16'h0010, 16'h0000, 16'h0000, 16'h0100, 16'h0000};
    logic         lds  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] exp  [5] = '{16'h0010, 16'h0011, 16'h0012, 16'h0100, 16'h0101};
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(sels[i], vals[i], lds[i], 1'b0);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL fifo_full: cmd_ready=%0b want 0", cmd_ready); end
    for (int i = 0; i < 5; i++) begin
      recv(d, c, m);
      checks++;
      if (d !== exp[i]) begin errors++; $display("FAIL fifo_order%0d: got %h want %h", i, d, exp[i]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_one_latency();
    test_rst_mid();
    test_back_to_back();
    test_chain();
    test_dbl_load_carry();
`ifdef ARITH_CMD_FIFO_EN
    test_fifo();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
